// File: rtl/yadan_test_monitor_pkg.sv
// Shared types for the multi-channel test monitor.
// State codes are fixed so firmware/LED decoding of state_o stays stable.
package yadan_test_monitor_pkg;

    typedef enum logic [2:0] {
        TmonIdle    = 3'd0,
        TmonRun     = 3'd1,
        TmonSettle  = 3'd2,
        TmonPass    = 3'd3,
        TmonFail    = 3'd4,
        TmonTimeout = 3'd5
    } tmon_state_e;

endpackage

// File: rtl/yadan_test_mon_cnt.sv
// Saturating counter with synchronous clear and an at-limit compare.
// o_at_limit is high while the count equals LIMIT, so the next increment
// is the one that completes LIMIT+1 counted cycles.
module yadan_test_mon_cnt #(
    parameter int unsigned CNT_W = 20,
    parameter int unsigned LIMIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_at_limit
);

    localparam logic [CNT_W-1:0] LimitVal = CNT_W'(LIMIT);

    logic [CNT_W-1:0] r_cnt;

    // Count up on i_inc, hold at all-ones, clear has priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_at_limit = (r_cnt == LimitVal);

endmodule

// File: rtl/yadan_test_monitor.sv
// Multi-channel pass/fail/timeout monitor fed by regfile taps.
// Optional sim banner: define YADAN_TEST_MON_DISPLAY_EN.
module yadan_test_monitor
    import yadan_test_monitor_pkg::*;
#(
    parameter int unsigned     NUM_CH      = 1,
    parameter int unsigned     DATA_W      = 32,
    parameter logic [DATA_W-1:0] DONE_VAL  = 'd1,
    parameter logic [DATA_W-1:0] PASS_VAL  = 'd1,
    parameter int unsigned     SETTLE_CYC  = 5,
    parameter int unsigned     TIMEOUT_CYC = 50000,
    parameter int unsigned     CNT_W       = 20,
    localparam int unsigned    CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_i,
    input  logic [NUM_CH*DATA_W-1:0] ch_done_i,
    input  logic [NUM_CH*DATA_W-1:0] ch_result_i,
    input  logic [NUM_CH*DATA_W-1:0] ch_testnum_i,
    output logic [2:0]               state_o,
    output logic                     done_o,
    output logic                     pass_o,
    output logic                     fail_o,
    output logic                     timeout_o,
    output logic [CH_W-1:0]          fail_ch_o,
    output logic [DATA_W-1:0]        fail_testnum_o,
    output logic [CNT_W-1:0]         cycle_cnt_o
);

    tmon_state_e       r_state, w_state_d;
    logic [NUM_CH-1:0] r_done_lat;
    logic [NUM_CH-1:0] w_done_hit;
    logic [NUM_CH-1:0] w_res_ok;
    logic              w_all_done;
    logic              w_tmo_hit;
    logic              w_settle_hit;
    logic [CH_W-1:0]   w_fail_ch;
    logic [DATA_W-1:0] w_fail_tn;
    logic [CNT_W-1:0]  r_cycle;
    logic              r_pass, r_fail, r_timeout;
    logic [CH_W-1:0]   r_fail_ch;
    logic [DATA_W-1:0] r_fail_tn;

    // Per-channel tap decode.
    always_comb begin
        w_done_hit = '0;
        w_res_ok   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_done_hit[c] = (ch_done_i[c*DATA_W +: DATA_W] == DONE_VAL);
            w_res_ok[c]   = (ch_result_i[c*DATA_W +: DATA_W] == PASS_VAL);
        end
    end

    // Lowest failing channel wins: scan downwards so the last hit is the lowest index.
    always_comb begin
        w_fail_ch = '0;
        w_fail_tn = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (!w_res_ok[c]) begin
                w_fail_ch = CH_W'(c);
                w_fail_tn = ch_testnum_i[c*DATA_W +: DATA_W];
            end
        end
    end

    // Latches set on this very edge count toward all-done.
    assign w_all_done = &(r_done_lat | w_done_hit);

    yadan_test_mon_cnt #(
        .CNT_W (CNT_W),
        .LIMIT (TIMEOUT_CYC - 1)
    ) u_tmo_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (!en_i || (r_state == TmonIdle)),
        .i_inc      (en_i && (r_state == TmonRun)),
        .o_at_limit (w_tmo_hit)
    );

    yadan_test_mon_cnt #(
        .CNT_W (CNT_W),
        .LIMIT (SETTLE_CYC)
    ) u_settle_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (!en_i || (r_state != TmonSettle)),
        .i_inc      (en_i && (r_state == TmonSettle)),
        .o_at_limit (w_settle_hit)
    );

    // Next-state: all-done beats timeout; terminal states hold until en_i drops.
    always_comb begin
        w_state_d = r_state;
        if (!en_i) begin
            w_state_d = TmonIdle;
        end else begin
            case (r_state)
                TmonIdle:   w_state_d = TmonRun;
                TmonRun: begin
                    if (w_all_done) begin
                        w_state_d = TmonSettle;
                    end else if (w_tmo_hit) begin
                        w_state_d = TmonTimeout;
                    end
                end
                TmonSettle: begin
                    if (w_settle_hit) begin
                        w_state_d = (&w_res_ok) ? TmonPass : TmonFail;
                    end
                end
                default:    w_state_d = r_state;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= TmonIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Sticky done latches, only armed in RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_done_lat <= '0;
        end else if (!en_i || (r_state == TmonIdle)) begin
            r_done_lat <= '0;
        end else if (r_state == TmonRun) begin
            r_done_lat <= r_done_lat | w_done_hit;
        end
    end

    // Saturating RUN+SETTLE cycle counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cycle <= '0;
        end else if (!en_i || (r_state == TmonIdle)) begin
            r_cycle <= '0;
        end else if (((r_state == TmonRun) || (r_state == TmonSettle)) && (r_cycle != '1)) begin
            r_cycle <= r_cycle + 1'b1;
        end
    end

    // Registered result flags follow the next state so they rise with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pass    <= 1'b0;
            r_fail    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_pass    <= (w_state_d == TmonPass);
            r_fail    <= (w_state_d == TmonFail);
            r_timeout <= (w_state_d == TmonTimeout);
        end
    end

    // Failing channel / test index captured at the sampling edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fail_ch <= '0;
            r_fail_tn <= '0;
        end else if (!en_i || (r_state == TmonIdle)) begin
            r_fail_ch <= '0;
            r_fail_tn <= '0;
        end else if ((r_state == TmonSettle) && w_settle_hit && !(&w_res_ok)) begin
            r_fail_ch <= w_fail_ch;
            r_fail_tn <= w_fail_tn;
        end
    end

    assign state_o        = r_state;
    assign pass_o         = r_pass;
    assign fail_o         = r_fail;
    assign timeout_o      = r_timeout;
    assign done_o         = r_pass | r_fail | r_timeout;
    assign fail_ch_o      = r_fail_ch;
    assign fail_testnum_o = r_fail_tn;
    assign cycle_cnt_o    = r_cycle;

`ifdef YADAN_TEST_MON_DISPLAY_EN
    logic [2:0] r_disp_prev;

    // Sim-only banner, printed once on entry to a terminal state.
    always @(negedge clk) begin
        if (rst && (r_state != r_disp_prev)) begin
            case (r_state)
                TmonPass:    $display("test pass");
                TmonFail:    $display("test fail ch=%0d inst=%2d", r_fail_ch, r_fail_tn);
                TmonTimeout: $display("Time out %0d", r_cycle);
                default:     ;
            endcase
        end
        r_disp_prev <= r_state;
    end
`endif

endmodule

// File: tb/tb_yadan_test_monitor.sv
// Directed + randomized bench for yadan_test_monitor (NUM_CH=4, TIMEOUT_CYC=100).
module tb_yadan_test_monitor;

    localparam int NCH    = 4;
    localparam int DW     = 32;
    localparam int SETTLE = 5;
    localparam int TMO    = 100;
    localparam int CW     = 20;

    localparam int S_IDLE = 0, S_RUN = 1, S_SETTLE = 2, S_PASS = 3, S_FAIL = 4, S_TMO = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              en_i;
    logic [NCH*DW-1:0] ch_done, ch_res, ch_tn;
    logic [2:0]        state_o;
    logic              done_o, pass_o, fail_o, timeout_o;
    logic [1:0]        fail_ch_o;
    logic [DW-1:0]     fail_testnum_o;
    logic [CW-1:0]     cycle_cnt_o;

    int checks   = 0;
    int failures = 0;

    int          g_done_at [NCH];
    logic [31:0] g_res     [NCH];
    logic [31:0] g_tn      [NCH];

    yadan_test_monitor #(
        .NUM_CH      (NCH),
        .DATA_W      (DW),
        .DONE_VAL    (32'h1),
        .PASS_VAL    (32'h1),
        .SETTLE_CYC  (SETTLE),
        .TIMEOUT_CYC (TMO),
        .CNT_W       (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en_i           (en_i),
        .ch_done_i      (ch_done),
        .ch_result_i    (ch_res),
        .ch_testnum_i   (ch_tn),
        .state_o        (state_o),
        .done_o         (done_o),
        .pass_o         (pass_o),
        .fail_o         (fail_o),
        .timeout_o      (timeout_o),
        .fail_ch_o      (fail_ch_o),
        .fail_testnum_o (fail_testnum_o),
        .cycle_cnt_o    (cycle_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rnd_not1();
        logic [31:0] v;
        v = $urandom;
        if (v == 32'h1) v = 32'h0;
        return v;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, ".state"},   64'(state_o), 64'd0);
        chk({tag, ".done"},    64'(done_o), 64'd0);
        chk({tag, ".pass"},    64'(pass_o), 64'd0);
        chk({tag, ".fail"},    64'(fail_o), 64'd0);
        chk({tag, ".timeout"}, 64'(timeout_o), 64'd0);
        chk({tag, ".fail_ch"}, 64'(fail_ch_o), 64'd0);
        chk({tag, ".fail_tn"}, 64'(fail_testnum_o), 64'd0);
        chk({tag, ".cycle"},   64'(cycle_cnt_o), 64'd0);
    endtask

    task automatic drive_random_done();
        for (int c = 0; c < NCH; c++) ch_done[c*DW +: DW] = rnd_not1();
    endtask

    // Runs one scenario from g_* against a model: the run ends SETTLE+1 edges after the
    // last channel's done edge, or on the TMO-th RUN edge if some channel never finishes.
    task automatic run_scn(input string name, input bit skip_idle, input int abort_at);
        int          last;
        bit          all_ok;
        int          fin;
        int          term;
        int          fch;
        logic [31:0] ftn;
        int          exp_state;

        last   = 0;
        all_ok = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            if (g_done_at[c] < 1 || g_done_at[c] > TMO) all_ok = 1'b0;
            else if (g_done_at[c] > last) last = g_done_at[c];
        end
        fch = 0;
        ftn = '0;
        if (all_ok) begin
            fin  = last + SETTLE + 1;
            term = S_PASS;
            for (int c = NCH - 1; c >= 0; c--) begin
                if (g_res[c] != 32'h1) begin
                    term = S_FAIL;
                    fch  = c;
                    ftn  = g_tn[c];
                end
            end
        end else begin
            fin  = TMO;
            term = S_TMO;
        end

        for (int c = 0; c < NCH; c++) begin
            ch_res[c*DW +: DW] = g_res[c];
            ch_tn[c*DW +: DW]  = g_tn[c];
        end
        drive_random_done();

        if (!skip_idle) begin
            en_i = 1'b0;
            @(posedge clk); #1;
            chk_all_zero({name, ".idle"});
        end

        en_i = 1'b1;
        @(posedge clk); #1;
        chk({name, ".run_entry"}, 64'(state_o), 64'(S_RUN));
        chk({name, ".cycle0"},    64'(cycle_cnt_o), 64'd0);

        for (int k = 1; k <= fin; k++) begin
            for (int c = 0; c < NCH; c++)
                ch_done[c*DW +: DW] = (k == g_done_at[c]) ? 32'h1 : rnd_not1();
            @(posedge clk); #1;
            if (k == fin)                 exp_state = term;
            else if (all_ok && k >= last) exp_state = S_SETTLE;
            else                          exp_state = S_RUN;
            chk($sformatf("%s.state@%0d", name, k), 64'(state_o), 64'(exp_state));
            chk($sformatf("%s.done@%0d", name, k), 64'(done_o), 64'(k == fin));
            if (k == abort_at) begin
                #2 rst = 1'b0;
                #1 chk_all_zero({name, ".async_rst"});
                @(negedge clk) rst = 1'b1;
                return;
            end
        end

        chk({name, ".pass"},    64'(pass_o), 64'(term == S_PASS));
        chk({name, ".fail"},    64'(fail_o), 64'(term == S_FAIL));
        chk({name, ".timeout"}, 64'(timeout_o), 64'(term == S_TMO));
        chk({name, ".cycle"},   64'(cycle_cnt_o), 64'(fin));
        chk({name, ".fail_ch"}, 64'(fail_ch_o), 64'(fch));
        chk({name, ".fail_tn"}, 64'(fail_testnum_o), 64'(ftn));

        for (int h = 0; h < 3; h++) begin
            drive_random_done();
            @(posedge clk); #1;
            chk($sformatf("%s.hold_state%0d", name, h), 64'(state_o), 64'(term));
            chk($sformatf("%s.hold_done%0d", name, h), 64'(done_o), 64'd1);
        end
    endtask

    initial begin
        rst     = 1'b0;
        en_i    = 1'b0;
        ch_done = '0;
        ch_res  = '0;
        ch_tn   = '0;
        #2 chk_all_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;

        // All channels done together at RUN edge 10, all pass: cycle_cnt ends at 16.
        for (int c = 0; c < NCH; c++) begin
            g_done_at[c] = 10; g_res[c] = 32'h1; g_tn[c] = $urandom;
        end
        run_scn("single_pass", 1'b0, -1);

        // Staggered dones, channel 2 fails with test index 17.
        g_done_at[0] = 3; g_done_at[1] = 7; g_done_at[2] = 9; g_done_at[3] = 12;
        g_res[0] = 32'h1; g_res[1] = 32'h1; g_res[2] = 32'h0; g_res[3] = 32'h1;
        for (int c = 0; c < NCH; c++) g_tn[c] = $urandom;
        g_tn[2] = 32'd17;
        run_scn("fail_ch2", 1'b0, -1);

        // Channel 1 never finishes: timeout after exactly 100 RUN edges.
        g_done_at[0] = 4; g_done_at[1] = 0; g_done_at[2] = 50; g_done_at[3] = 99;
        for (int c = 0; c < NCH; c++) begin g_res[c] = 32'h1; g_tn[c] = $urandom; end
        run_scn("timeout", 1'b0, -1);

        // Single-cycle pulses; last one lands on the timeout edge and still wins.
        g_done_at[0] = 5; g_done_at[1] = TMO; g_done_at[2] = 20; g_done_at[3] = 1;
        for (int c = 0; c < NCH; c++) begin g_res[c] = 32'h1; g_tn[c] = $urandom; end
        run_scn("done_on_tmo_edge", 1'b0, -1);

        // Async reset mid-SETTLE, then rerun straight out of reset with en_i held high.
        for (int c = 0; c < NCH; c++) begin
            g_done_at[c] = 4; g_res[c] = 32'h1; g_tn[c] = $urandom;
        end
        run_scn("abort", 1'b0, 7);
        run_scn("after_rst", 1'b1, -1);

        for (int s = 0; s < 8; s++) begin
            for (int c = 0; c < NCH; c++) begin
                g_done_at[c] = $urandom_range(1, 110);
                g_res[c]     = ($urandom_range(0, 3) == 0) ? rnd_not1() : 32'h1;
                g_tn[c]      = $urandom;
            end
            run_scn($sformatf("rand%0d", s), 1'b0, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
